// File: rtl/spi_slave_pkg.sv
// ---------------------------------------------------------------------------
// spi_slave_pkg
//   Shared definitions for the SPI mode-0 responder: default word geometry,
//   the fill word sent when no transmit data is ready, the SPI mode
//   constants and the FSM state encoding.
// ---------------------------------------------------------------------------
package spi_slave_pkg;

  // SPI mode 0: clock idles low, data is sampled on the rising edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 8;
  localparam logic [DATA_W_DEF-1:0] FILL_WORD_DEF = 8'hFF;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_slave_sync_edge.sv
// ---------------------------------------------------------------------------
// spi_slave_sync_edge
//   Brings one asynchronous SPI pin into the clk domain through a 2-flop
//   synchroniser, then keeps one history flop so edges can be detected on
//   the synchronised level.
// Ports
//   clk    in   system clock
//   reset  in   asynchronous active-low reset (flops load RST_VAL)
//   din    in   asynchronous pin
//   level  out  synchronised level
//   rise   out  one-cycle flag: synchronised level went 0 -> 1
//   fall   out  one-cycle flag: synchronised level went 1 -> 0
// ---------------------------------------------------------------------------
module spi_slave_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic hist_r;

  // Two-stage synchroniser followed by the history stage used for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
      hist_r <= RST_VAL;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      hist_r <= sync_r;
    end
  end

  assign level = sync_r;
  assign rise  = sync_r & ~hist_r;
  assign fall  = ~sync_r & hist_r;

endmodule

// File: rtl/spi_slave.sv
// ---------------------------------------------------------------------------
// spi_slave
//   SPI mode-0 responder (CPOL=0, CPHA=0, MSB first). SCK/CS_N/MOSI are
//   oversampled in the clk domain (fclk >= 8x fsck). Received words are
//   assembled on sclk rising edges; transmit words are shifted out on MISO on
//   sclk falling edges and reloaded from tx_data at every word boundary.
// Ports
//   clk, reset            system clock, asynchronous active-low reset
//   sclk, cs_n, mosi      asynchronous SPI pins from the master
//   miso, miso_oe         serial data to master and its output enable
//   rx_data, rx_valid     last complete received word, 1-clk update pulse
//   tx_data, tx_valid     next word to transmit and its freshness flag
//   tx_req                1-clk pulse: tx_data/tx_valid sampled this cycle
//   tx_underrun           1-clk pulse: load with tx_valid=0, FILL_WORD sent
//   word_cnt              complete words received in current frame (wraps)
//   frame_done, frame_err end-of-frame pulse; err set if frame ended mid-word
// ---------------------------------------------------------------------------
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter logic [DATA_W-1:0] FILL_WORD = FILL_WORD_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_req,
  output logic              tx_underrun,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  // ---------------- input synchronisers ----------------
  logic sclk_lvl_s, sclk_rise_s, sclk_fall_s;
  logic cs_lvl_s, cs_rise_s, cs_fall_s;
  logic mosi_lvl_s;
  logic unused_mosi_rise_s, unused_mosi_fall_s;

  spi_slave_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk   (clk),
    .reset (reset),
    .din   (sclk),
    .level (sclk_lvl_s),
    .rise  (sclk_rise_s),
    .fall  (sclk_fall_s)
  );

  spi_slave_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .clk   (clk),
    .reset (reset),
    .din   (cs_n),
    .level (cs_lvl_s),
    .rise  (cs_rise_s),
    .fall  (cs_fall_s)
  );

  spi_slave_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .reset (reset),
    .din   (mosi),
    .level (mosi_lvl_s),
    .rise  (unused_mosi_rise_s),
    .fall  (unused_mosi_fall_s)
  );

  // ---------------- state ----------------
  spi_state_e state_r, state_nxt;

  logic [1:0]        flush_cnt_r, flush_cnt_nxt;
  logic              armed_r, armed_nxt;
  logic [BIT_W-1:0]  bit_cnt_r, bit_cnt_nxt;
  logic [CNT_W-1:0]  word_cnt_r, word_cnt_nxt;
  logic [DATA_W-1:0] tx_shift_r, tx_shift_nxt;
  logic [DATA_W-1:0] rx_shift_r, rx_shift_nxt;
  logic [DATA_W-1:0] rx_data_r, rx_data_nxt;
  logic              rx_valid_r, rx_valid_nxt;
  logic              tx_req_r, tx_req_nxt;
  logic              tx_underrun_r, tx_underrun_nxt;
  logic              frame_done_r, frame_done_nxt;
  logic              frame_err_r, frame_err_nxt;
  logic              miso_r, miso_nxt;
  logic              miso_oe_r, miso_oe_nxt;

  logic [DATA_W-1:0] load_word_s;
  logic [DATA_W-1:0] rx_word_s;
  logic              flush_done_s;

  assign load_word_s  = tx_valid ? tx_data : FILL_WORD;
  assign rx_word_s    = {rx_shift_r[DATA_W-2:0], mosi_lvl_s};
  // The synchroniser flops come out of reset holding cs_n=1, which is not a
  // real observation of the pin. Arming waits until the pipeline has been
  // refilled from the pin so a frame already running at reset release is
  // not mistaken for one that started after arming.
  assign flush_done_s = (flush_cnt_r == 2'd3);

  // Arming: pipeline flush counter and the sticky armed flag.
  always_comb begin
    flush_cnt_nxt = flush_cnt_r;
    armed_nxt     = armed_r;
    if (!flush_done_s) begin
      flush_cnt_nxt = flush_cnt_r + 2'd1;
    end else begin
      flush_cnt_nxt = flush_cnt_r;
    end
    if (flush_done_s && cs_lvl_s) begin
      armed_nxt = 1'b1;
    end else begin
      armed_nxt = armed_r;
    end
  end

  // Next-state and datapath decode for the frame FSM.
  always_comb begin
    state_nxt       = state_r;
    bit_cnt_nxt     = bit_cnt_r;
    word_cnt_nxt    = word_cnt_r;
    tx_shift_nxt    = tx_shift_r;
    rx_shift_nxt    = rx_shift_r;
    rx_data_nxt     = rx_data_r;
    rx_valid_nxt    = 1'b0;
    tx_req_nxt      = 1'b0;
    tx_underrun_nxt = 1'b0;
    frame_done_nxt  = 1'b0;
    frame_err_nxt   = 1'b0;
    miso_oe_nxt     = miso_oe_r;

    case (state_r)
      ST_IDLE: begin
        if (armed_r && cs_fall_s) begin
          state_nxt       = ST_ACTIVE;
          bit_cnt_nxt     = {BIT_W{1'b0}};
          word_cnt_nxt    = {CNT_W{1'b0}};
          tx_shift_nxt    = load_word_s;
          tx_req_nxt      = 1'b1;
          tx_underrun_nxt = ~tx_valid;
          miso_oe_nxt     = 1'b1;
        end else begin
          miso_oe_nxt     = 1'b0;
        end
      end
      ST_ACTIVE: begin
        // Chip-select release wins over any sclk edge seen in the same cycle.
        if (cs_rise_s) begin
          state_nxt      = ST_IDLE;
          frame_done_nxt = 1'b1;
          frame_err_nxt  = (bit_cnt_r != {BIT_W{1'b0}});
          miso_oe_nxt    = 1'b0;
        end else if (sclk_rise_s) begin
          rx_shift_nxt = rx_word_s;
          if (bit_cnt_r == LAST_BIT) begin
            rx_data_nxt  = rx_word_s;
            rx_valid_nxt = 1'b1;
            word_cnt_nxt = word_cnt_r + CNT_W'(1);
            bit_cnt_nxt  = {BIT_W{1'b0}};
          end else begin
            bit_cnt_nxt  = bit_cnt_r + BIT_W'(1);
          end
        end else if (sclk_fall_s) begin
          // bit_cnt==0 on a falling edge means a whole word was just sampled.
          if (bit_cnt_r == {BIT_W{1'b0}}) begin
            tx_shift_nxt    = load_word_s;
            tx_req_nxt      = 1'b1;
            tx_underrun_nxt = ~tx_valid;
          end else begin
            tx_shift_nxt    = {tx_shift_r[DATA_W-2:0], 1'b0};
          end
        end else begin
          state_nxt = ST_ACTIVE;
        end
      end
      default: begin
        state_nxt   = ST_IDLE;
        miso_oe_nxt = 1'b0;
      end
    endcase

    // MISO follows the MSB of the shift register that will be current.
    if (state_nxt == ST_ACTIVE) begin
      miso_nxt = tx_shift_nxt[DATA_W-1];
    end else begin
      miso_nxt = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Datapath, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flush_cnt_r   <= 2'd0;
      armed_r       <= 1'b0;
      bit_cnt_r     <= {BIT_W{1'b0}};
      word_cnt_r    <= {CNT_W{1'b0}};
      tx_shift_r    <= {DATA_W{1'b0}};
      rx_shift_r    <= {DATA_W{1'b0}};
      rx_data_r     <= {DATA_W{1'b0}};
      rx_valid_r    <= 1'b0;
      tx_req_r      <= 1'b0;
      tx_underrun_r <= 1'b0;
      frame_done_r  <= 1'b0;
      frame_err_r   <= 1'b0;
      miso_r        <= 1'b0;
      miso_oe_r     <= 1'b0;
    end else begin
      flush_cnt_r   <= flush_cnt_nxt;
      armed_r       <= armed_nxt;
      bit_cnt_r     <= bit_cnt_nxt;
      word_cnt_r    <= word_cnt_nxt;
      tx_shift_r    <= tx_shift_nxt;
      rx_shift_r    <= rx_shift_nxt;
      rx_data_r     <= rx_data_nxt;
      rx_valid_r    <= rx_valid_nxt;
      tx_req_r      <= tx_req_nxt;
      tx_underrun_r <= tx_underrun_nxt;
      frame_done_r  <= frame_done_nxt;
      frame_err_r   <= frame_err_nxt;
      miso_r        <= miso_nxt;
      miso_oe_r     <= miso_oe_nxt;
    end
  end

  assign miso        = miso_r;
  assign miso_oe     = miso_oe_r;
  assign rx_data     = rx_data_r;
  assign rx_valid    = rx_valid_r;
  assign tx_req      = tx_req_r;
  assign tx_underrun = tx_underrun_r;
  assign word_cnt    = word_cnt_r;
  assign frame_done  = frame_done_r;
  assign frame_err   = frame_err_r;

endmodule

// File: tb/tb_spi_slave.sv
// ---------------------------------------------------------------------------
// tb_spi_slave
//   Directed bench for spi_slave: acts as the SPI master (mode 0, MSB first),
//   feeds transmit words on tx_req, and records rx words and pulses.
// ---------------------------------------------------------------------------
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       reset;
  logic       sclk, cs_n, mosi;
  logic       miso, miso_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_req, tx_underrun;
  logic [7:0] word_cnt;
  logic       frame_done, frame_err;

  spi_slave dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_req(tx_req),
    .tx_underrun(tx_underrun), .word_cnt(word_cnt),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [7:0] mosi_words[$];
  logic [7:0] miso_got[$];
  logic [7:0] rx_got[$];
  logic [7:0] tx_q[$];
  int req_cnt = 0, und_cnt = 0, fd_cnt = 0;
  logic last_err = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transmit-side user: supplies the next queued word after each tx_req.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_req) begin
        req_cnt++;
        if (tx_q.size() > 0) begin
          tx_data  = tx_q.pop_front();
          tx_valid = 1'b1;
        end else begin
          tx_valid = 1'b0;
        end
      end
      if (tx_underrun) und_cnt++;
    end
  end

  // Receive-side monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid) rx_got.push_back(rx_data);
      if (frame_done) begin
        fd_cnt++;
        last_err = frame_err;
      end
    end
  end

  // Master: clocks nbits of mosi_words; optionally ends the frame with the
  // last sclk fall and cs_n release at the same instant.
  task automatic run_frame(input int nbits, input bit jitter, input bit end_frame);
    logic [7:0] acc;
    logic [7:0] cur;
    int lo, hi;
    acc = 8'h00;
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      cur  = mosi_words[i / 8];
      mosi = cur[7 - (i % 8)];
      lo = jitter ? int'($urandom_range(5, 3)) : 4;
      hi = jitter ? int'($urandom_range(5, 3)) : 4;
      repeat (lo) @(negedge clk);
      acc  = {acc[6:0], miso};
      sclk = 1'b1;
      repeat (hi) @(negedge clk);
      sclk = 1'b0;
      if (end_frame && (i == nbits - 1)) cs_n = 1'b1;
      if ((i % 8) == 7) miso_got.push_back(acc);
    end
    repeat (8) @(negedge clk);
  endtask

  int rx_base, tx_base, req_base, und_base, fd_base, bad_rx, bad_tx;
  logic [7:0] exp_tx[$];
  logic [7:0] w;

  initial begin
    reset = 1'b0; sclk = 1'b0; cs_n = 1'b0; mosi = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
    check("rst_rx_data", {24'd0, rx_data}, 32'h0);
    check("rst_pulses", {27'd0, rx_valid, tx_req, tx_underrun, frame_done, frame_err}, 32'd0);
    check("rst_word_cnt", {24'd0, word_cnt}, 32'd0);

    // 1: reset released mid-frame; the frame must be dropped.
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      mosi = i[0];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (6) @(negedge clk);
    check("t1_no_rx", rx_got.size(), 32'd0);
    check("t1_no_txreq", req_cnt, 32'd0);
    check("t1_oe", {31'd0, miso_oe}, 32'd0);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);

    // 2: single word A5 in, 3C out.
    mosi_words = {8'hA5};
    tx_data = 8'h3C; tx_valid = 1'b1;
    rx_base = rx_got.size(); tx_base = miso_got.size();
    req_base = req_cnt; und_base = und_cnt; fd_base = fd_cnt;
    run_frame(8, 1'b0, 1'b1);
    check("t2_rx_cnt", rx_got.size() - rx_base, 32'd1);
    check("t2_rx_data", {24'd0, rx_got[rx_base]}, 32'hA5);
    check("t2_miso", {24'd0, miso_got[tx_base]}, 32'h3C);
    check("t2_word_cnt", {24'd0, word_cnt}, 32'd1);
    check("t2_frame_done", fd_cnt - fd_base, 32'd1);
    check("t2_frame_err", {31'd0, last_err}, 32'd0);
    check("t2_txreq", req_cnt - req_base, 32'd1);
    check("t2_oe_off", {31'd0, miso_oe}, 32'd0);

    // 3: three words, transmitter runs dry on the third.
    mosi_words = {8'h01, 8'h02, 8'h03};
    tx_data = 8'h11; tx_valid = 1'b1; tx_q.push_back(8'h22);
    rx_base = rx_got.size(); tx_base = miso_got.size();
    req_base = req_cnt; und_base = und_cnt;
    run_frame(24, 1'b0, 1'b1);
    check("t3_rx_cnt", rx_got.size() - rx_base, 32'd3);
    check("t3_rx", {8'd0, rx_got[rx_base], rx_got[rx_base+1], rx_got[rx_base+2]}, 32'h010203);
    check("t3_miso", {8'd0, miso_got[tx_base], miso_got[tx_base+1], miso_got[tx_base+2]}, 32'h1122FF);
    check("t3_underrun", und_cnt - und_base, 32'd1);
    check("t3_txreq", req_cnt - req_base, 32'd3);
    check("t3_word_cnt", {24'd0, word_cnt}, 32'd3);

    // 4: frame cut after 5 bits of the second word.
    mosi_words = {8'hC3, 8'h99};
    tx_data = 8'h5E; tx_valid = 1'b1; tx_q.push_back(8'h77);
    rx_base = rx_got.size(); fd_base = fd_cnt;
    run_frame(13, 1'b0, 1'b1);
    check("t4_rx_cnt", rx_got.size() - rx_base, 32'd1);
    check("t4_rx_data", {24'd0, rx_data}, 32'hC3);
    check("t4_word_cnt", {24'd0, word_cnt}, 32'd1);
    check("t4_frame_done", fd_cnt - fd_base, 32'd1);
    check("t4_frame_err", {31'd0, last_err}, 32'd1);

    // 5: reset asserted after 4 bits.
    mosi_words = {8'hF0};
    tx_data = 8'hAA; tx_valid = 1'b1;
    fd_base = fd_cnt;
    run_frame(4, 1'b0, 1'b0);
    check("t5_oe_before", {31'd0, miso_oe}, 32'd1);
    reset = 1'b0;
    #1;
    check("t5_rst_oe", {31'd0, miso_oe}, 32'd0);
    check("t5_rst_miso", {31'd0, miso}, 32'd0);
    check("t5_rst_rx_data", {24'd0, rx_data}, 32'h0);
    check("t5_rst_word_cnt", {24'd0, word_cnt}, 32'd0);
    repeat (3) @(negedge clk);
    cs_n = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    check("t5_no_frame_done", fd_cnt - fd_base, 32'd0);
    mosi_words = {8'h5A};
    rx_base = rx_got.size();
    run_frame(8, 1'b0, 1'b1);
    check("t5_rx_cnt", rx_got.size() - rx_base, 32'd1);
    check("t5_rx_data", {24'd0, rx_data}, 32'h5A);
    check("t5_frame_done", fd_cnt - fd_base, 32'd1);

    // 6: 256 random words with jittered sclk; word counter wraps.
    mosi_words.delete();
    exp_tx.delete();
    for (int i = 0; i < 256; i++) begin
      w = 8'($urandom);
      mosi_words.push_back(w);
      w = 8'($urandom);
      exp_tx.push_back(w);
      if (i > 0) tx_q.push_back(w);
    end
    tx_data = exp_tx[0]; tx_valid = 1'b1;
    rx_base = rx_got.size(); tx_base = miso_got.size();
    und_base = und_cnt; req_base = req_cnt;
    run_frame(256 * 8, 1'b1, 1'b1);
    check("t6_rx_cnt", rx_got.size() - rx_base, 32'd256);
    check("t6_tx_cnt", miso_got.size() - tx_base, 32'd256);
    bad_rx = 0; bad_tx = 0;
    if ((rx_got.size() - rx_base) == 256 && (miso_got.size() - tx_base) == 256) begin
      for (int i = 0; i < 256; i++) begin
        if (rx_got[rx_base + i] !== mosi_words[i]) bad_rx++;
        if (miso_got[tx_base + i] !== exp_tx[i]) bad_tx++;
      end
    end else begin
      bad_rx = 999; bad_tx = 999;
    end
    check("t6_rx_words", bad_rx, 32'd0);
    check("t6_tx_words", bad_tx, 32'd0);
    check("t6_word_cnt_wrap", {24'd0, word_cnt}, 32'd0);
    check("t6_underrun", und_cnt - und_base, 32'd0);
    check("t6_txreq", req_cnt - req_base, 32'd256);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
